// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: read-owner encoding and default memory geometry.
// Imported by the memory arbiter and its helpers.
package mem_arbiter_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter for the fetch port.
// Counts denied cycles up to MAX; clr has priority over inc.
module starve_counter #(
    parameter int MAX = 4,
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic         at_max,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Count denials, saturating at MAX, cleared on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != MAX_V) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between fetch and data ports.
// Data has priority; a starved fetch is forced through after MAX_WAIT.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   conflict_cnt
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic          run;
    logic          at_max;
    logic          wait_inc;
    logic          wait_clr;
    logic [CW-1:0] wait_count;
    logic          conflict;
    owner_e        owner_q;
    owner_e        owner_d;
    logic [15:0]   conflict_q;

    // Grants are suppressed in reset and while halted.
    assign run    = rst_n & ~halt;
    assign if_gnt = run & if_req & (~d_req | at_max);
    assign d_gnt  = run & d_req & ~(if_req & at_max);

    // Halt freezes the counter: neither inc nor clr.
    assign wait_inc = ~halt & if_req & ~if_gnt;
    assign wait_clr = ~halt & (if_gnt | ~if_req);

    starve_counter #(
        .MAX (MAX_WAIT)
    ) u_wait (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (wait_inc),
        .clr    (wait_clr),
        .at_max (at_max),
        .count  (wait_count)
    );

    // Drive the shared memory from the winner; idle bus reads as zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            d_gnt: begin
                mem_addr  = d_addr;
                mem_wdata = d_we ? d_wdata : '0;
            end
            if_gnt: begin
                mem_addr = if_addr;
            end
            default: ;
        endcase
    end

    assign mem_en = if_gnt | d_gnt;
    assign mem_we = d_gnt & d_we;

    // Decide who owns the read data returning next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        unique case (1'b1)
            if_gnt:         owner_d = OWN_IF;
            d_gnt && !d_we: owner_d = OWN_D;
            default: ;
        endcase
    end

    // Read-owner register; reset drops any owed response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign if_rvalid = (owner_q == OWN_IF);
    assign d_rvalid  = (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

    assign conflict = if_req & d_req & ~halt;

    // Saturating count of contended, non-halted cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else if (conflict && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 10, word-address width of shared memory.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 4, consecutive fetch denials before fetch is forced to win.
REQ-004 The interface SHALL have one clock, clk, and reset rst_n, which is asynchronous and active-low; it SHALL list the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  block all new grants while high
- if_req  in  1  instruction fetch request, held until if_gnt
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data word address
- d_wdata  in  DW  write data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  DW  data read data
- mem_en  out  1  shared memory access strobe
- mem_we  out  1  shared memory write enable
- mem_addr  out  AW  shared memory address
- mem_wdata  out  DW  shared memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after a read strobe
- conflict_cnt  out  16  saturating count of cycles in which both requests were present and not halted

Function
REQ-005 At most one grant SHALL be issued per cycle; if_gnt and d_gnt SHALL never both be 1.
REQ-006 Grants SHALL be combinational in the request cycle; mem_en/mem_we/mem_addr/mem_wdata SHALL be driven from the winner in the same cycle.
REQ-007 With no grant, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold the value 0.
REQ-008 Priority: data SHALL win over fetch unless the wait counter equals MAX_WAIT; in that case fetch SHALL win.
REQ-009 The wait counter SHALL increment, saturating at MAX_WAIT, on each cycle with if_req=1 and no if_gnt; it SHALL clear on if_gnt or when if_req=0.
REQ-010 A granted read SHALL assert the owner's rvalid exactly one cycle later, with rdata = mem_rdata in that cycle; the other rvalid SHALL stay 0.
REQ-011 A granted write SHALL produce no rvalid; the memory SHALL update at the grant-cycle clock edge.
REQ-012 The read-owner register SHALL record NONE/IF/D each cycle; rdata outputs SHALL be 0 when their rvalid is 0.
REQ-013 halt=1 SHALL suppress all grants and freeze the wait counter; an rvalid already owed SHALL still be delivered.
REQ-014 Back-to-back grants SHALL be allowed every cycle: a new grant may coincide with the previous read's rvalid.
REQ-015 conflict_cnt SHALL saturate at 16'hFFFF and not wrap.

Reset
REQ-016 When rst_n=0, the block SHALL asynchronously force the wait counter to 0, the read-owner register to NONE, both rvalid to 0, and conflict_cnt to 0.
REQ-017 A read granted in the cycle that reset asserts SHALL produce no rvalid after reset release.
REQ-018 Combinational grants SHALL be 0 while rst_n=0.

Structure
REQ-019 The owner encoding (NONE=2'd0, IF=2'd1, D=2'd2) SHALL reside in the shared CPU package together with the AW and DW defaults.
REQ-020 The wait counter SHALL be a sub-module, starve_counter, with inputs inc and clr, parameter MAX, and output at_max.
REQ-021 All sequential logic SHALL use the rising edge of clk.

Verification
REQ-022 Verification SHALL cover if_req only, if_addr=0x010, mem_rdata=0x8C020004: if_gnt in the same cycle, then if_rvalid=1 and if_rdata=0x8C020004 in the next cycle.
REQ-023 Verification SHALL cover d_req write, d_addr=0x020, d_wdata=0xDEADBEEF, followed by a d_req read of 0x020: the read SHALL return d_rdata=0xDEADBEEF and no rvalid SHALL follow the write.
REQ-024 Verification SHALL cover both requests held continuously for 10 cycles with MAX_WAIT=4: grant order D,D,D,D,IF and repeating, with conflict_cnt=10.
REQ-025 Verification SHALL cover halt=1 asserted the cycle after a d read grant: d_rvalid still pulses once, there are no further grants while halt=1, and the wait counter is unchanged.
REQ-026 Verification SHALL cover rst_n pulsed low mid-read: both rvalid stay 0 after release, the wait counter and conflict_cnt read 0, and the first post-reset if_req is granted immediately.
REQ-027 Verification SHALL cover conflict_cnt preloaded to 0xFFFE followed by 3 conflict cycles: the counter holds at 0xFFFF.
